// File: rtl/lcd_row_arbiter_pkg.sv
// Shared types and helpers for the LCD row arbiter.
package lcd_row_arbiter_pkg;

  localparam int unsigned LCD_ROW_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ROTATE,
    ARB_MSG
  } lcd_arb_state_t;

  // Round-robin successor of idx among n producers.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lcd_row_arbiter_rr_pick.sv
// Combinational wrap-around priority pick: first set bit at or after i_start.
module lcd_row_arbiter_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_valid,
  input  logic [$clog2(N)-1:0] i_start,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(N);

  // Scan N positions starting at i_start; the first valid one wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_found && i_valid[IW'((32'(i_start) + k) % N)]) begin
        o_found = 1'b1;
        o_idx   = IW'((32'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/lcd_row_arbiter.sv
// Time-shares the 2x16 LCD rows between round-robin producers and an
// urgent one-shot message channel.
module lcd_row_arbiter
  import lcd_row_arbiter_pkg::*;
#(
  parameter int unsigned          NUM_REQ     = 4,
  parameter int unsigned          HOLD_CYCLES = 50_000_000,
  parameter int unsigned          MSG_CYCLES  = 100_000_000,
  parameter logic [LCD_ROW_W-1:0] ROW_INIT    = "????????????????"
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*LCD_ROW_W-1:0]   req_row_a,
  input  logic [NUM_REQ*LCD_ROW_W-1:0]   req_row_b,
  input  logic                           msg_valid,
  input  logic [LCD_ROW_W-1:0]           msg_row_a,
  input  logic [LCD_ROW_W-1:0]           msg_row_b,
  output logic                           msg_ready,
  output logic [LCD_ROW_W-1:0]           row_A,
  output logic [LCD_ROW_W-1:0]           row_B,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           owner_valid
);

  localparam int unsigned OWN_W   = $clog2(NUM_REQ);
  localparam int unsigned MAX_CYC = (HOLD_CYCLES > MSG_CYCLES) ? HOLD_CYCLES : MSG_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MSG_LOAD  = CNT_W'(MSG_CYCLES - 1);

  lcd_arb_state_t         r_state, w_state_n;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n;
  logic [OWN_W-1:0]       r_owner, w_owner_n;
  logic [OWN_W-1:0]       r_ptr, w_ptr_n;
  logic                   r_owner_valid, w_owner_valid_n;
  logic [LCD_ROW_W-1:0]   r_row_a, w_row_a_n;
  logic [LCD_ROW_W-1:0]   r_row_b, w_row_b_n;

  logic                   w_accept;
  logic [OWN_W-1:0]       w_start;
  logic                   w_found;
  logic [OWN_W-1:0]       w_pick;
  logic [LCD_ROW_W-1:0]   w_req_a [NUM_REQ];
  logic [LCD_ROW_W-1:0]   w_req_b [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_a[g] = req_row_a[g*LCD_ROW_W +: LCD_ROW_W];
    assign w_req_b[g] = req_row_b[g*LCD_ROW_W +: LCD_ROW_W];
  end

  assign msg_ready = (r_state != ARB_MSG) & ~reset;
  assign w_accept  = msg_valid & msg_ready;

  // One picker serves all grant paths: idle uses the RR pointer, message exit
  // starts at the saved owner, rotation starts after the owner (owner last).
  always_comb begin
    unique case (r_state)
      ARB_IDLE: w_start = r_ptr;
      ARB_MSG:  w_start = r_owner;
      default:  w_start = OWN_W'(rr_next(32'(r_owner), NUM_REQ));
    endcase
  end

  lcd_row_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
    .i_valid (req_valid),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Next-state, counter, owner and row selection.
  always_comb begin
    w_state_n       = r_state;
    w_cnt_n         = r_cnt;
    w_owner_n       = r_owner;
    w_ptr_n         = r_ptr;
    w_owner_valid_n = r_owner_valid;
    w_row_a_n       = r_row_a;
    w_row_b_n       = r_row_b;

    if (w_accept) begin
      w_state_n       = ARB_MSG;
      w_cnt_n         = MSG_LOAD;
      w_owner_valid_n = 1'b0;
      w_row_a_n       = msg_row_a;
      w_row_b_n       = msg_row_b;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_found) w_state_n = ARB_ROTATE;
        end
        ARB_ROTATE: begin
          if (!req_valid[r_owner] || (r_cnt == '0)) begin
            w_state_n = w_found ? ARB_ROTATE : ARB_IDLE;
          end else begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end
        end
        ARB_MSG: begin
          if (r_cnt == '0) begin
            w_state_n = w_found ? ARB_ROTATE : ARB_IDLE;
          end else begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_n = ARB_IDLE;
      endcase

      // A decision point (idle, expiry, owner drop, message exit) with a hit
      // is a grant; fresh dwell and pointer follow the picked index.
      if (w_found && ((r_state == ARB_IDLE) ||
                      (r_state == ARB_ROTATE && (!req_valid[r_owner] || r_cnt == '0)) ||
                      (r_state == ARB_MSG && r_cnt == '0))) begin
        w_owner_n       = w_pick;
        w_owner_valid_n = 1'b1;
        w_cnt_n         = HOLD_LOAD;
        w_ptr_n         = OWN_W'(rr_next(32'(w_pick), NUM_REQ));
      end

      // Rows are loaded from the owner being shown next, so owner and text
      // change on the same edge; leaving for idle restores the init text.
      if (w_state_n == ARB_ROTATE) begin
        w_row_a_n = w_req_a[w_owner_n];
        w_row_b_n = w_req_b[w_owner_n];
      end else if (w_state_n == ARB_IDLE && r_state != ARB_IDLE) begin
        w_owner_valid_n = 1'b0;
        w_row_a_n       = ROW_INIT;
        w_row_b_n       = ROW_INIT;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARB_IDLE;
      r_cnt         <= '0;
      r_owner       <= '0;
      r_ptr         <= '0;
      r_owner_valid <= 1'b0;
      r_row_a       <= ROW_INIT;
      r_row_b       <= ROW_INIT;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      r_owner       <= w_owner_n;
      r_ptr         <= w_ptr_n;
      r_owner_valid <= w_owner_valid_n;
      r_row_a       <= w_row_a_n;
      r_row_b       <= w_row_b_n;
    end
  end

  assign row_A       = r_row_a;
  assign row_B       = r_row_b;
  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;

endmodule

// File: doc/lcd_row_arbiter.md
Name: lcd_row_arbiter

Overview:
- Shares the 2x16 character LCD between several text producers (game state/control debug, score readout, menu text, etc.) plus one urgent one-shot message channel.
- Continuous producers are rotated round-robin, each for a fixed dwell time.
- A one-shot message preempts rotation for a fixed display time.
- Sits between the row-formatting logic and LCD_module, driving its row_A/row_B inputs.

Parameters:
- NUM_REQ, 4, number of continuous row producers (2..8).
- HOLD_CYCLES, 50_000_000, dwell per producer in clk cycles (1 s at 50 MHz).
- MSG_CYCLES, 100_000_000, display time of an urgent message in clk cycles.
- ROW_INIT, "????????????????", 128-bit idle/reset text for both rows.

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  level; bit i high means producer i wants display time.
- req_row_a  in  NUM_REQ*128  producer i top row at bits [128*i +: 128].
- req_row_b  in  NUM_REQ*128  producer i bottom row, same packing.
- msg_valid  in  1  urgent message offer.
- msg_row_a  in  128  urgent message top row.
- msg_row_b  in  128  urgent message bottom row.
- msg_ready  out  1  message accepted when msg_valid & msg_ready.
- row_A  out  128  to LCD_module top row (registered).
- row_B  out  128  to LCD_module bottom row (registered).
- owner  out  $clog2(NUM_REQ)  index of the producer currently shown.
- owner_valid  out  1  high while a producer (not a message, not idle) is shown.

Behaviour:
- States: ARB_IDLE, ARB_ROTATE, ARB_MSG. One down-counter, wide enough for max(HOLD_CYCLES, MSG_CYCLES).
- Reset (any cycle, including mid-message):
  - state ARB_IDLE; row_A = row_B = ROW_INIT; owner = 0; owner_valid = 0; counter = 0.
  - msg_ready = 0 during reset and 1 in the first cycle after it.
- msg_ready = (state != ARB_MSG) & ~reset, combinational.
- Message handshake has top priority in every non-MSG state:
  - On accept, latch msg_row_a/b into row_A/B on the next edge.
  - state becomes ARB_MSG, counter = MSG_CYCLES-1, owner_valid = 0, owner is held (saved).
  - msg_valid during ARB_MSG is ignored (msg_ready low); nothing is queued.
- ARB_MSG: rows are frozen at the latched message. When counter = 0:
  - If req_valid[owner], go to ARB_ROTATE with the same owner and a fresh dwell.
  - Otherwise pick the first valid producer after owner, in round-robin order.
  - If none is valid, go to ARB_IDLE with rows = ROW_INIT.
- ARB_IDLE:
  - Any req_valid bit grants the lowest index at or after the round-robin pointer (pointer = last owner + 1, wraps modulo NUM_REQ).
  - Grant: owner set, owner_valid = 1, counter = HOLD_CYCLES-1.
- ARB_ROTATE:
  - Every cycle, row_A/B <= req_row_a/b of owner (live tracking, 1-cycle latency).
  - counter decrements each cycle.
  - At counter = 0:
    - If another producer is valid, grant the next valid after owner.
    - Otherwise, if owner is still valid, keep owner and reload the dwell.
    - Otherwise, go to ARB_IDLE.
  - If req_valid[owner] drops mid-dwell, the switch happens next cycle:
    - next valid after owner with a fresh dwell, or
    - ARB_IDLE with rows = ROW_INIT and owner_valid = 0.
- Simultaneous events:
  - Message accept beats dwell expiry and owner drop in the same cycle; the expiry is discarded and the owner is re-evaluated on message exit.
  - Grant selection uses the req_valid value sampled in the decision cycle.
- Round-robin wrap: the scan after index NUM_REQ-1 continues at 0; owner itself is considered last.

Decomposition:
- Shared package (alongside enum_type): LCD_ROW_W = 128; typedef lcd_arb_state_t enum {ARB_IDLE, ARB_ROTATE, ARB_MSG}.
- Sub-module rr_pick: combinational; inputs valid vector and start index; outputs found and index of the first set bit at or after start, wrapping. Used for both grant and rotation.

Test Plan (NUM_REQ=4, HOLD_CYCLES=4, MSG_CYCLES=6):
- Reset, req_valid=0 -> row_A=row_B=ROW_INIT, owner_valid=0, msg_ready=1 one cycle after reset releases.
- req_valid=4'b0101 held -> owner sequence 0,2,0,2 with each owner shown exactly 4 cycles; row_A equals the owner's req_row_a one cycle after the grant.
- Owner 2 showing, producer 2 changes req_row_b mid-dwell -> row_B follows on the next cycle.
- Owner 2 showing, drop req_valid[2] at dwell cycle 1 -> next cycle owner=0 with a fresh 4-cycle dwell.
- Message accepted at the same cycle as dwell expiry of owner 0 (req 4'b0011) -> message rows shown for 6 cycles, msg_ready=0 throughout, second msg_valid ignored; then owner 0 resumes for 4 cycles, then owner 1.
- Reset asserted during ARB_MSG cycle 3 -> next cycle rows=ROW_INIT, ARB_IDLE, owner=0, owner_valid=0.
